// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int unsigned BE_WIDTH = 4;

endpackage

// File: rtl/arb_prio2.sv
// Two-requester priority selector; prio_d picks which side wins a tie.
module arb_prio2 (
  input  logic req_i,
  input  logic req_d,
  input  logic prio_d,
  output logic gnt_i,
  output logic gnt_d
);

  always_comb begin
    gnt_d = req_d & (prio_d | ~req_i);
    gnt_i = req_i & ~gnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / memory-stage arbiter onto one shared memory port, one transaction in flight.
// Define MEM_ARB_RR_EN for alternating priority on ties; default is fixed D-over-I.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  output logic                     i_gnt,
  output logic                     i_rvalid,
  output logic [DATA_WIDTH-1:0]    i_rdata,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [BE_WIDTH-1:0]      d_be,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic                     m_req,
  output logic                     m_we,
  output logic [BE_WIDTH-1:0]      m_be,
  output logic [ADDRESS_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0]    m_wdata,
  input  logic                     m_ready,
  input  logic                     m_rvalid,
  input  logic [DATA_WIDTH-1:0]    m_rdata,
  output logic                     busy
);

  arb_state_e                 state_q, state_d;
  owner_e                     owner_q;
  logic                       we_q;
  logic [BE_WIDTH-1:0]        be_q;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic [DATA_WIDTH-1:0]      i_rdata_q;
  logic [DATA_WIDTH-1:0]      d_rdata_q;
  logic                       idle;
  logic                       prio_d;
  logic                       arb_gnt_i;
  logic                       arb_gnt_d;

  assign idle = (state_q == IDLE);

`ifdef MEM_ARB_RR_EN
  owner_e last_q;

  assign prio_d = (last_q == OWN_I);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_I;
    end else if (arb_gnt_d) begin
      last_q <= OWN_D;
    end else if (arb_gnt_i) begin
      last_q <= OWN_I;
    end
  end
`else
  assign prio_d = 1'b1;
`endif

  // Requests only reach the selector in IDLE, so grants are single-cycle by construction.
  arb_prio2 u_prio (
    .req_i  (i_req & idle),
    .req_d  (d_req & idle),
    .prio_d (prio_d),
    .gnt_i  (arb_gnt_i),
    .gnt_d  (arb_gnt_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_gnt_i | arb_gnt_d) state_d = ISSUE;
      ISSUE:   if (m_ready)               state_d = WAIT;
      WAIT:    if (m_rvalid)              state_d = RESP;
      RESP:                               state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_comb begin
    i_gnt    = arb_gnt_i;
    d_gnt    = arb_gnt_d;
    m_req    = (state_q == ISSUE);
    busy     = !idle;
    i_rvalid = (state_q == RESP) && (owner_q == OWN_I);
    d_rvalid = (state_q == RESP) && (owner_q == OWN_D);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_I;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (arb_gnt_d) begin
        owner_q <= OWN_D;
        we_q    <= d_we;
        be_q    <= d_be;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
      end else if (arb_gnt_i) begin
        owner_q <= OWN_I;
        we_q    <= 1'b0;
        be_q    <= '1;
        addr_q  <= i_addr;
        wdata_q <= '0;
      end
      if ((state_q == WAIT) && m_rvalid) begin
        if (owner_q == OWN_D) begin
          d_rdata_q <= m_rdata;
        end else begin
          i_rdata_q <= m_rdata;
        end
      end
    end
  end

  assign m_we    = we_q;
  assign m_be    = be_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: timeline-based transaction model plus directed literal checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        m_ready = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        busy;

  mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus configuration for the memory responder
  int          cfg_stall = 0;
  int          cfg_lat   = 0;
  logic [31:0] cfg_rdata = '0;
  bit          spur_rvalid = 1'b0;

  // Transaction timeline model: a grant at cycle g with s stall cycles and
  // w extra response cycles gives m_req on g+1..g+1+s, memory response at
  // g+2+s+w, rvalid at g+3+s+w and a free arbiter at g+4+s+w.
  int          cyc = 0;
  int          rel = 0;
  bit          tx_active = 1'b0;
  int          t_g, t_s, t_w;
  bit          t_own_d;
  bit          last_d = 1'b0;
  bit          grant_now, win_d;
  logic        e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_i_rdata, e_d_rdata;
  logic        e_i_gnt, e_d_gnt, e_m_req, e_i_rvalid, e_d_rvalid, e_busy;

  task automatic model_eval();
    e_i_gnt = 0; e_d_gnt = 0; e_m_req = 0; e_i_rvalid = 0; e_d_rvalid = 0; e_busy = 0;
    grant_now = 0; win_d = 0;
    m_ready  = 1'b0;
    m_rvalid = spur_rvalid;
    m_rdata  = cfg_rdata;
    if (!rst_n) begin
      tx_active = 0; last_d = 0;
      e_we = 0; e_be = '0; e_addr = '0; e_wdata = '0; e_i_rdata = '0; e_d_rdata = '0;
      return;
    end
    if (!tx_active) begin
      if (d_req || i_req) begin
        grant_now = 1;
`ifdef MEM_ARB_RR_EN
        win_d = d_req && (!i_req || !last_d);
`else
        win_d = d_req;
`endif
        e_d_gnt = win_d;
        e_i_gnt = !win_d;
      end
    end else begin
      rel = cyc - t_g;
      e_busy = 1;
      if (rel >= 1 && rel <= 1 + t_s) begin
        e_m_req = 1;
        m_ready = (rel == 1 + t_s);
      end
      if (rel == 2 + t_s + t_w) m_rvalid = 1'b1;
      if (rel == 3 + t_s + t_w) begin
        e_d_rvalid = t_own_d;
        e_i_rvalid = !t_own_d;
      end
    end
  endtask

  task automatic model_commit();
    if (!rst_n) return;
    if (grant_now) begin
      tx_active = 1; t_g = cyc; t_s = cfg_stall; t_w = cfg_lat; t_own_d = win_d; last_d = win_d;
      if (win_d) begin
        e_we = d_we; e_be = d_be; e_addr = d_addr; e_wdata = d_wdata;
      end else begin
        e_we = 0; e_be = 4'hF; e_addr = i_addr; e_wdata = '0;
      end
    end else if (tx_active) begin
      if (rel == 2 + t_s + t_w) begin
        if (t_own_d) e_d_rdata = cfg_rdata;
        else         e_i_rdata = cfg_rdata;
      end
      if (rel == 3 + t_s + t_w) tx_active = 0;
    end
  endtask

  // Snapshots and counters for directed checks
  logic        s_i_gnt, s_d_gnt, s_m_req, s_m_we, s_i_rvalid, s_d_rvalid, s_busy;
  logic [31:0] s_m_addr, s_m_wdata, s_i_rdata, s_d_rdata;
  int          cnt_mreq = 0, cnt_gnt = 0, cnt_rvalid = 0;
  bit          gnt_log[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("i_gnt",    i_gnt,    e_i_gnt);
      check("d_gnt",    d_gnt,    e_d_gnt);
      check("m_req",    m_req,    e_m_req);
      check("busy",     busy,     e_busy);
      check("i_rvalid", i_rvalid, e_i_rvalid);
      check("d_rvalid", d_rvalid, e_d_rvalid);
      check("m_addr",   m_addr,   e_addr);
      check("m_we",     m_we,     e_we);
      check("m_be",     m_be,     e_be);
      check("m_wdata",  m_wdata,  e_wdata);
      check("i_rdata",  i_rdata,  e_i_rdata);
      check("d_rdata",  d_rdata,  e_d_rdata);
      s_i_gnt = i_gnt; s_d_gnt = d_gnt; s_m_req = m_req; s_m_we = m_we;
      s_i_rvalid = i_rvalid; s_d_rvalid = d_rvalid; s_busy = busy;
      s_m_addr = m_addr; s_m_wdata = m_wdata; s_i_rdata = i_rdata; s_d_rdata = d_rdata;
      if (m_req) cnt_mreq++;
      if (i_gnt || d_gnt) begin
        cnt_gnt++;
        gnt_log.push_back(d_gnt);
      end
      if (i_rvalid || d_rvalid) cnt_rvalid++;
    end
  end

  task automatic step(int n = 1);
    for (int k = 0; k < n; k++) begin
      model_eval();
      @(negedge clk);
      @(posedge clk);
      model_commit();
      #1;
      cyc++;
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset state and quiet first cycles after release
    step(3);
    check("reset_m_addr", s_m_addr, 64'h0);
    check("reset_busy", s_busy, 64'h0);
    rst_n = 1'b1;
    step(2);
    check("post_reset_idle", s_busy, 64'h0);

    // Single zero-wait fetch
    cfg_stall = 0; cfg_lat = 0; cfg_rdata = 32'h00500093;
    i_req = 1'b1; i_addr = 32'h100;
    step();
    check("fetch_gnt_c0", s_i_gnt, 64'h1);
    i_req = 1'b0;
    step();
    check("fetch_mreq_c1", s_m_req, 64'h1);
    check("fetch_maddr_c1", s_m_addr, 64'h100);
    step(2);
    check("fetch_rvalid_c3", s_i_rvalid, 64'h1);
    check("fetch_rdata_c3", s_i_rdata, 64'h00500093);
    check("fetch_no_drvalid", s_d_rvalid, 64'h0);
    step();

    // Simultaneous requests: data write wins, fetch follows
    cfg_rdata = 32'h0;
    i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    step();
    check("both_d_gnt", s_d_gnt, 64'h1);
    check("both_no_i_gnt", s_i_gnt, 64'h0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    check("wr_m_we", s_m_we, 64'h1);
    check("wr_m_wdata", s_m_wdata, 64'hDEADBEEF);
    step(2);
    check("wr_d_rvalid", s_d_rvalid, 64'h1);
    cfg_rdata = 32'h12345678;
    step();
    check("then_i_gnt", s_i_gnt, 64'h1);
    i_req = 1'b0;
    step(3);
    check("then_i_rdata", s_i_rdata, 64'h12345678);

    // Continuous contention over four transactions
    gnt_log.delete();
    cfg_rdata = 32'hA5A5_0001;
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'h3;
    step(16);
    i_req = 1'b0; d_req = 1'b0;
    step(2);
    check("contend_count", gnt_log.size(), 64'd4);
    if (gnt_log.size() == 4) begin
`ifdef MEM_ARB_RR_EN
      check("contend_seq", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 64'b1010);
`else
      check("contend_seq", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 64'b1111);
`endif
    end

    // Memory stalls m_ready for five cycles
    cfg_stall = 5; cfg_lat = 0; cfg_rdata = 32'hCAFE_F00D;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF;
    step();
    d_req = 1'b0;
    i_req = 1'b1; i_addr = 32'h300;
    cnt_mreq = 0; cnt_gnt = 0;
    step(6);
    check("stall_mreq_cycles", cnt_mreq, 64'd6);
    check("stall_no_gnt", cnt_gnt, 64'd0);
    check("stall_maddr", s_m_addr, 64'h3000);
    check("stall_busy", s_busy, 64'h1);
    i_req = 1'b0;
    step(2);
    check("stall_d_rdata", s_d_rdata, 64'hCAFE_F00D);
    cfg_stall = 0;

    // Reset during WAIT, then a stale response
    cfg_lat = 10; cfg_rdata = 32'hBAD0_BAD0;
    i_req = 1'b1; i_addr = 32'h400;
    step();
    i_req = 1'b0;
    step(3);
    cnt_rvalid = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    spur_rvalid = 1'b1;
    step();
    spur_rvalid = 1'b0;
    step(3);
    check("rst_no_rvalid", cnt_rvalid, 64'd0);
    check("rst_idle", s_busy, 64'h0);
    check("rst_i_rdata", s_i_rdata, 64'h0);

    // Spurious m_rvalid in IDLE and ISSUE
    cfg_stall = 2; cfg_lat = 1; cfg_rdata = 32'h0BAD_CAFE;
    cnt_rvalid = 0;
    spur_rvalid = 1'b1;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000; d_be = 4'h1;
    step();
    d_req = 1'b0;
    step(3);
    check("spur_no_rvalid", cnt_rvalid, 64'd0);
    spur_rvalid = 1'b0;
    step(4);
    check("spur_one_rvalid", cnt_rvalid, 64'd1);
    check("spur_d_rdata", s_d_rdata, 64'h0BAD_CAFE);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, data width; ADDRESS_WIDTH, default 32, address width.
REQ-002 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 i_req / i_addr  in  1 / ADDRESS_WIDTH  fetch-side read request and address.
REQ-006 i_gnt / i_rvalid / i_rdata  out  1 / 1 / DATA_WIDTH  fetch grant, read-data valid, read data.
REQ-007 d_req / d_we / d_be / d_addr / d_wdata  in  1 / 1 / 4 / ADDRESS_WIDTH / DATA_WIDTH  memory-stage request, write enable, byte enables, address, write data.
REQ-008 d_gnt / d_rvalid / d_rdata  out  1 / 1 / DATA_WIDTH  memory-stage grant, response valid (read data or write ack), read data.
REQ-009 m_req / m_we / m_be / m_addr / m_wdata  out  1 / 1 / 4 / ADDRESS_WIDTH / DATA_WIDTH  shared memory port command.
REQ-010 m_ready / m_rvalid / m_rdata  in  1 / 1 / DATA_WIDTH  command accept, response valid (reads and writes), response data.
REQ-011 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, with at most one memory transaction outstanding.
REQ-013 In IDLE, if any request is pending, the winner's gnt SHALL be asserted combinationally that cycle, the command and owner SHALL be latched at the edge, and the FSM SHALL move to ISSUE.
REQ-014 Default priority SHALL be d_req over i_req, because the memory-stage instruction is older.
REQ-015 The i_gnt and d_gnt outputs SHALL each be a one-cycle pulse and SHALL never both be high.
REQ-016 In ISSUE, m_req SHALL be high and the m_* command fields SHALL be driven from the latched registers, stable until accepted; on m_req&m_ready the FSM SHALL move to WAIT.
REQ-017 In WAIT, the FSM SHALL hold until m_rvalid, capture m_rdata, and move to RESP.
REQ-018 In RESP, the owner's rvalid SHALL be high for exactly one cycle with the registered rdata; the FSM SHALL then return to IDLE.
REQ-019 A zero-wait memory (m_ready high in ISSUE, m_rvalid in the first WAIT cycle) SHALL give gnt at cycle 0, m_req at cycle 1, and rvalid at cycle 3; the next grant SHALL be possible at cycle 4.
REQ-020 The block SHALL ignore m_rvalid in IDLE, ISSUE and RESP.
REQ-021 The block SHALL ignore i_req and d_req outside IDLE.
REQ-022 A requester SHALL hold req and its command fields until gnt, and the arbiter SHALL sample them only in the gnt cycle.
REQ-023 The non-owner rdata output SHALL hold its previous value.
REQ-024 i_rdata and d_rdata SHALL be valid only while the corresponding rvalid is high.

Reset
REQ-025 While rst_n is low: state SHALL be IDLE; all gnt, rvalid and m_req SHALL be 0; m_we and busy SHALL be 0; m_be SHALL be 0; m_addr, m_wdata, i_rdata and d_rdata SHALL be 0; the priority pointer SHALL be D-first.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction with no rvalid issued, and any later m_rvalid for it SHALL be discarded per REQ-020.
REQ-027 The block SHALL take no action in the first cycle after rst_n deasserts unless a req is present.

Configuration
REQ-028 Macro MEM_ARB_RR_EN SHALL select the arbitration policy.
REQ-029 With MEM_ARB_RR_EN defined, a one-bit last-owner register SHALL give priority to the side not granted last whenever both requests are pending; the register SHALL reset to I-last, so D wins first.
REQ-030 Without MEM_ARB_RR_EN, arbitration SHALL be fixed D-over-I, the last-owner register SHALL not exist, and fetch starvation SHALL be permitted.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the FSM state typedef (IDLE/ISSUE/WAIT/RESP), the owner encoding (OWN_I=0, OWN_D=1) and the byte-enable width constant (4).
REQ-032 One sub-module, arb_prio2, SHALL be used: a two-requester priority selector with inputs req_i, req_d and prio_d, and one-hot grant outputs.
REQ-033 All other logic SHALL be flat inside mem_arbiter.

Verification
REQ-034 i_req with i_addr=0x100, zero-wait memory returning m_rdata=0x00500093 -> i_gnt at cycle 0, m_addr=0x100 at cycle 1, i_rvalid at cycle 3 with i_rdata=0x00500093, and d_rvalid stays 0.
REQ-035 i_req and d_req both high (d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0xF), fixed mode -> d_gnt first with m_we=1, m_wdata=0xDEADBEEF; d_rvalid, then i_gnt at the next IDLE.
REQ-036 Both requests held continuously for 4 transactions -> fixed mode grants D,D,D,D; with MEM_ARB_RR_EN, grants D,I,D,I.
REQ-037 m_ready held low for 5 cycles in ISSUE -> m_req and m_addr stay stable for 6 cycles, busy=1, and no gnt is issued.
REQ-038 rst_n pulsed low during WAIT, then a stale m_rvalid arrives -> no i_rvalid or d_rvalid, and state is IDLE.
REQ-039 A spurious m_rvalid asserted in IDLE and in ISSUE -> ignored, with no rvalid output.
